xlink_token_tx: RTL

- Drains 9-bit tokens from an upstream token FIFO and serialises each one onto a 2-wire XLink as wire transitions.
- Sits between a token FIFO read port (first-word-fall-through: dout valid whenever not empty) and the link output pads.
- Each token is sent as 10 transitions: 9 encode the token, 1 returns both wires to 0.

---
 rtl/xlink_token_tx_pkg.sv | 27 ++
 rtl/xlink_token_tx_timer.sv | 33 +++
 rtl/xlink_token_tx.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/xlink_token_tx_pkg.sv
// Shared definitions for the XLink token transmitter.
// Holds the token geometry, the transmitter state encoding and the
// wire-toggle helper used when turning a token bit into a link transition.
package xlink_token_tx_pkg;

    localparam int TOKEN_WIDTH           = 9;
    localparam int TOKEN_CTRL_BIT        = 8;
    localparam int TRANSITIONS_PER_TOKEN = 10;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_GAP  = 2'd2
    } tx_state_e;

    // A 1 is signalled by toggling wire 1, a 0 by toggling wire 0.
    function automatic logic [1:0] wire_toggle(input logic [1:0] wires, input logic bit_val);
        logic [1:0] result;
        if (bit_val) begin
            result = {~wires[1], wires[0]};
        end else begin
            result = {wires[1], ~wires[0]};
        end
        return result;
    endfunction

endpackage

// File: rtl/xlink_token_tx_timer.sv
// Loadable down-counter with a zero flag.
// Ports:
//   clk, reset      - clock and asynchronous active-low reset
//   load, load_val  - load the counter (load has priority over dec)
//   dec             - decrement by one, saturating at zero
//   zero            - high while the counter holds zero
module xlink_tx_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_r;

    // Counter register: load, or count down and stick at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != {WIDTH{1'b0}})) begin
            cnt_r <= cnt_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign zero = (cnt_r == {WIDTH{1'b0}});

endmodule

// File: rtl/xlink_token_tx.sv
// XLink token transmitter: pops 9-bit tokens from a first-word-fall-through
// FIFO and sends each as 10 wire transitions (ctrl bit, data MSB first, then a
// terminator returning both wires to 00).
// Ports:
//   clk, reset   - clock and asynchronous active-low reset
//   enable       - permits fetching a new token (sampled only when idle)
//   fifo_dout    - FIFO head token, bit 8 = control flag
//   fifo_empty   - FIFO empty flag
//   fifo_rd_en   - combinational one-cycle pop strobe
//   tx_wire      - link wires {w1,w0}
//   busy         - high while a token is being sent or in the post-token gap
//   tok_count    - completed-token counter, wraps
module xlink_token_tx
    import xlink_token_tx_pkg::*;
#(
    parameter int BIT_DELAY = 4,
    parameter int TOKEN_GAP = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [TOKEN_WIDTH-1:0] fifo_dout,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    output logic [1:0]             tx_wire,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   tok_count
);

    localparam logic [7:0] BIT_RELOAD = 8'(BIT_DELAY - 1);
    localparam logic [7:0] GAP_RELOAD = (TOKEN_GAP > 0) ? 8'(TOKEN_GAP - 1) : 8'd0;
    localparam logic       GAP_EN     = (TOKEN_GAP > 0) ? 1'b1 : 1'b0;
    // idx_r counts data bits already sent; IDX_TERM means only the
    // terminator is left, IDX_DONE means the terminator has gone out.
    localparam logic [3:0] IDX_TERM   = 4'(TRANSITIONS_PER_TOKEN - 2);
    localparam logic [3:0] IDX_DONE   = 4'(TRANSITIONS_PER_TOKEN - 1);

    tx_state_e               state_r, next_state_s;
    logic [TOKEN_CTRL_BIT-1:0] data_r;
    logic [3:0]              idx_r;
    logic [1:0]              tx_wire_r;
    logic                    busy_r;
    logic [CNT_WIDTH-1:0]    tok_count_r;

    logic fetch_req_s, fetch_s, fire_s, done_s;
    logic bit_load_s, bit_dec_s, bit_zero_s;
    logic gap_load_s, gap_dec_s, gap_zero_s;

    assign fetch_req_s = (state_r == TX_IDLE) && enable && !fifo_empty;
    assign fifo_rd_en  = fetch_req_s;

    xlink_tx_timer #(.WIDTH(8)) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (bit_load_s),
        .load_val (BIT_RELOAD),
        .dec      (bit_dec_s),
        .zero     (bit_zero_s)
    );

    xlink_tx_timer #(.WIDTH(8)) u_gap_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (gap_load_s),
        .load_val (GAP_RELOAD),
        .dec      (gap_dec_s),
        .zero     (gap_zero_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= TX_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and control decode. Transition 0 goes out on the fetch edge,
    // so SEND only handles transitions 1..9 and the completion cycle.
    always_comb begin
        next_state_s = state_r;
        fetch_s      = 1'b0;
        fire_s       = 1'b0;
        done_s       = 1'b0;
        bit_load_s   = 1'b0;
        bit_dec_s    = 1'b0;
        gap_load_s   = 1'b0;
        gap_dec_s    = 1'b0;
        case (state_r)
            TX_IDLE: begin
                if (fetch_req_s) begin
                    next_state_s = TX_SEND;
                    fetch_s      = 1'b1;
                    bit_load_s   = 1'b1;
                end else begin
                    next_state_s = TX_IDLE;
                end
            end
            TX_SEND: begin
                if (idx_r == IDX_DONE) begin
                    done_s = 1'b1;
                    if (GAP_EN) begin
                        next_state_s = TX_GAP;
                        gap_load_s   = 1'b1;
                    end else begin
                        next_state_s = TX_IDLE;
                    end
                end else if (bit_zero_s) begin
                    fire_s     = 1'b1;
                    bit_load_s = 1'b1;
                end else begin
                    bit_dec_s = 1'b1;
                end
            end
            TX_GAP: begin
                if (gap_zero_s) begin
                    next_state_s = TX_IDLE;
                end else begin
                    gap_dec_s = 1'b1;
                end
            end
            default: begin
                next_state_s = TX_IDLE;
            end
        endcase
    end

    // Datapath: shift register, transition index, wires, counter and busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_r      <= 8'd0;
            idx_r       <= 4'd0;
            tx_wire_r   <= 2'b00;
            busy_r      <= 1'b0;
            tok_count_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (fetch_s) begin
                data_r    <= fifo_dout[TOKEN_CTRL_BIT-1:0];
                idx_r     <= 4'd0;
                tx_wire_r <= wire_toggle(tx_wire_r, fifo_dout[TOKEN_CTRL_BIT]);
            end else if (fire_s) begin
                if (idx_r == IDX_TERM) begin
                    // Exactly one wire is high here; toggling it returns to 00.
                    tx_wire_r <= wire_toggle(tx_wire_r, tx_wire_r[1]);
                    idx_r     <= IDX_DONE;
                end else begin
                    tx_wire_r <= wire_toggle(tx_wire_r, data_r[TOKEN_CTRL_BIT-1]);
                    data_r    <= {data_r[TOKEN_CTRL_BIT-2:0], 1'b0};
                    idx_r     <= idx_r + 4'd1;
                end
            end
            if (done_s) begin
                tok_count_r <= tok_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            busy_r <= (next_state_s != TX_IDLE);
        end
    end

    assign tx_wire   = tx_wire_r;
    assign busy      = busy_r;
    assign tok_count = tok_count_r;

endmodule
